// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/data memory arbiter.
// Imported by the arbiter top and its round-robin grant logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DATA = 2'b10
    } owner_t;

    localparam int DEF_TIMEOUT = 255;

    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/unified_mem_arbiter_rr.sv
// Two-way round-robin grant: the requester that did not own the
// memory last wins a tie. Purely combinational, one-hot grant.
import mem_arb_pkg::*;

module rr_arbiter2 (
    input  logic       req_if,
    input  logic       req_data,
    input  owner_t     last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_if && req_data) begin
            grant = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
        end else if (req_if) begin
            grant = 2'b01;
        end else if (req_data) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// access; every output is registered, with watchdog and alignment errors.
import mem_arb_pkg::*;

module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic [1:0]    owner
);

    localparam int CW = cnt_width(TIMEOUT);

    state_t        state, state_n;
    owner_t        own_q, own_n;
    owner_t        last_q, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    grant;

    logic          en_n, we_n, if_ack_n, d_ack_n, err_n, busy_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n, if_rdata_n, d_rdata_n;

    assign owner = own_q;

    rr_arbiter2 u_rr (
        .req_if     (if_req),
        .req_data   (d_req),
        .last_owner (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_n    = state;
        own_n      = own_q;
        last_n     = last_q;
        cnt_n      = cnt;
        en_n       = 1'b0;
        we_n       = mem_we;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        if_ack_n   = 1'b0;
        d_ack_n    = 1'b0;
        err_n      = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    own_n   = grant[0] ? OWN_IF : OWN_DATA;
                    last_n  = own_n;
                    addr_n  = grant[0] ? if_addr : d_addr;
                    we_n    = grant[1] & d_we;
                    wdata_n = grant[1] ? d_wdata : '0;
                    if (addr_n[1:0] != 2'b00) begin
                        // misaligned: answer at once, memory untouched
                        state_n  = RESP;
                        we_n     = 1'b0;
                        if_ack_n = grant[0];
                        d_ack_n  = grant[1];
                        err_n    = 1'b1;
                    end else begin
                        state_n = ACCESS;
                        en_n    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                en_n  = 1'b1;
                cnt_n = cnt + CW'(1);
                if (mem_ready) begin
                    state_n  = RESP;
                    en_n     = 1'b0;
                    we_n     = 1'b0;
                    if_ack_n = (own_q == OWN_IF);
                    d_ack_n  = (own_q == OWN_DATA);
                    if (own_q == OWN_IF) begin
                        if_rdata_n = mem_rdata;
                    end else if (!mem_we) begin
                        d_rdata_n = mem_rdata;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n  = RESP;
                    en_n     = 1'b0;
                    we_n     = 1'b0;
                    if_ack_n = (own_q == OWN_IF);
                    d_ack_n  = (own_q == OWN_DATA);
                    err_n    = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
                own_n   = OWN_NONE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                own_n   = OWN_NONE;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            own_q     <= OWN_NONE;
            last_q    <= OWN_DATA;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            own_q     <= own_n;
            last_q    <= last_n;
            cnt       <= cnt_n;
            mem_en    <= en_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if_ack    <= if_ack_n;
            d_ack     <= d_ack_n;
            err       <= err_n;
            if_rdata  <= if_rdata_n;
            d_rdata   <= d_rdata_n;
            busy      <= busy_n;
        end
    end

endmodule
